zbus_addr_mux_tx: RTL

ZBUS_ADDR_MUX_TX -- requirements
Module: zbus_addr_mux_tx

---
 rtl/zbus_pkg.sv | 14 +
 rtl/zbus_strobe_sync.sv | 36 +++
 rtl/zbus_addr_mux_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/zbus_pkg.sv
// rtl/zbus_pkg.sv - shared constants and FSM encoding for the Z80 address mux transmitter
package zbus_pkg;

  localparam int   HOLD_MAX  = 15;
  localparam logic FA_SEL_LO = 1'b0;
  localparam logic FA_SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } zbus_state_e;

endpackage

// File: rtl/zbus_strobe_sync.sv
// rtl/zbus_strobe_sync.sv - synchronises MREQ/IORQ and emits a one-clock pulse on the rising edge of strb
module zbus_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mreq_n,
  input  logic iorq_n,
  output logic req
);

  logic [1:0] mreq_sync_q, mreq_sync_d;
  logic [1:0] iorq_sync_q, iorq_sync_d;
  logic       strb_q, strb_d;
  logic       strb;

  always_comb begin
    mreq_sync_d = {mreq_sync_q[0], mreq_n};
    iorq_sync_d = {iorq_sync_q[0], iorq_n};
    strb        = ~(mreq_sync_q[1] & iorq_sync_q[1]);
    strb_d      = strb;
    req         = strb & ~strb_q;
  end

  // Synchronisers idle high and the edge copy idles low, so reset release cannot look like a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_sync_q <= 2'b11;
      iorq_sync_q <= 2'b11;
      strb_q      <= 1'b0;
    end else begin
      mreq_sync_q <= mreq_sync_d;
      iorq_sync_q <= iorq_sync_d;
      strb_q      <= strb_d;
    end
  end

endmodule

// File: rtl/zbus_addr_mux_tx.sv
// rtl/zbus_addr_mux_tx.sv - sends each captured Z80 address as a low-then-high byte frame on fa/fa_sel
module zbus_addr_mux_tx
  import zbus_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] zaddr_in,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        ovr_clr,
  output logic [7:0]  fa,
  output logic        fa_sel,
  output logic        busy,
  output logic        frame_done,
  output logic        ovr
);

  localparam int         HOLD_C  = (HOLD < 1) ? 1 : ((HOLD > HOLD_MAX) ? HOLD_MAX : HOLD);
  localparam logic [3:0] HOLD_M1 = 4'(HOLD_C - 1);

  zbus_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  frame_hi_q, frame_hi_d;
  logic [7:0]  fa_q, fa_d;
  logic        fa_sel_q, fa_sel_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        req;
  logic        start;
  logic        accept;
  logic        overrun;
  logic [15:0] start_addr;

  zbus_strobe_sync u_strobe_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mreq_n (mreq_n),
    .iorq_n (iorq_n),
    .req    (req)
  );

  always_comb begin
    shadow_d   = req ? zaddr_in : shadow_q;
    req_d      = req;
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_hi_d = frame_hi_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    fa_d       = fa_q;
    fa_sel_d   = fa_sel_q;
    done_d     = 1'b0;
    start      = 1'b0;
    accept     = 1'b0;
    start_addr = shadow_q;

    unique case (state_q)
      IDLE: start = req_q;
      LO: begin
        accept = req_q;
        if (cnt_q == 4'd0) begin
          state_d  = HI;
          cnt_d    = HOLD_M1;
          fa_d     = frame_hi_q;
          fa_sel_d = FA_SEL_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          done_d = 1'b1;
          if (pend_vld_q) begin
            // Pending frame goes out first; a coincident request takes the slot it frees.
            start      = 1'b1;
            start_addr = pend_q;
            pend_vld_d = req_q;
            pend_d     = req_q ? shadow_q : pend_q;
          end else if (req_q) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          accept = req_q;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun = accept & pend_vld_q;
    if (accept) begin
      pend_d     = shadow_q;
      pend_vld_d = 1'b1;
    end

    if (start) begin
      state_d    = LO;
      cnt_d      = HOLD_M1;
      frame_hi_d = start_addr[15:8];
      fa_d       = start_addr[7:0];
      fa_sel_d   = FA_SEL_LO;
    end

    ovr_d = overrun | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shadow_q   <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      frame_hi_q <= 8'h00;
      fa_q       <= 8'h00;
      fa_sel_q   <= FA_SEL_LO;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      frame_hi_q <= frame_hi_d;
      fa_q       <= fa_d;
      fa_sel_q   <= fa_sel_d;
      req_q      <= req_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign fa         = fa_q;
  assign fa_sel     = fa_sel_q;
  assign busy       = (state_q != IDLE) | pend_vld_q;
  assign frame_done = done_q;
  assign ovr        = ovr_q;

endmodule
